// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
//   Shared types and elaboration helpers for the serial adder/subtractor:
//   the control FSM state encoding, the beat count per operation and the
//   width of the beat counter.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Smallest counter width allowed, even when a single beat needs no count.
  localparam int unsigned MIN_CNT_W = 1;

  // Beats needed to push WIDTH bits through a CHUNK-bit chain. A zero CHUNK
  // is rejected elsewhere; the guard only avoids a divide-by-zero first.
  function automatic int unsigned beats(input int unsigned width,
                                        input int unsigned chunk);
    return (chunk == 0) ? 1 : width / chunk;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n_beats);
    return (n_beats > 1) ? $clog2(n_beats) : MIN_CNT_W;
  endfunction

endpackage

// File: rtl/serial_adder_fa_cell.sv
// fa_cell
//   One-bit full adder; CHUNK copies form the per-beat ripple chain.
//   a, b : operand bits      ci : carry in
//   s    : sum bit           co : carry out
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  always_comb begin
    s  = a ^ b ^ ci;
    co = (a & b) | (ci & (a ^ b));
  end

endmodule

// File: rtl/serial_adder.sv
// serial_adder
//   Multi-cycle adder/subtractor. A WIDTH-bit operand pair is processed
//   CHUNK bits per clock through a ripple chain of fa_cell instances, with
//   the carry held in a register between beats.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid / in_ready : operand handshake (ready only while idle)
//   a, b, cin, sub      : operands, carry-in, subtract select (A+~B+1)
//   out_valid/out_ready : result handshake; result held until accepted
//   sum, cout, ovf      : result mod 2^WIDTH, carry-out (1 = no borrow on
//                         subtract), two's-complement overflow
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned BEATS = beats(WIDTH, CHUNK);
  localparam int unsigned CNT_W = cnt_width(BEATS);

  generate
    if ((WIDTH < 1) || (CHUNK < 1) ||
        ((WIDTH % ((CHUNK < 1) ? 1 : CHUNK)) != 0)) begin : g_bad_params
      $error("serial_adder: CHUNK must be >= 1 and divide WIDTH exactly");
    end
  endgenerate

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               c_msb_q, c_msb_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [CHUNK:0]     chain_c;
  logic [CHUNK-1:0]   chunk_s;
  logic               accept;
  logic               last_beat;

  // Per-beat ripple chain over the low CHUNK bits of the shift registers.
  assign chain_c[0] = carry_q;

  for (genvar i = 0; i < CHUNK; i++) begin : g_chain
    fa_cell u_fa (
      .a  (a_sh_q[i]),
      .b  (b_sh_q[i]),
      .ci (chain_c[i]),
      .s  (chunk_s[i]),
      .co (chain_c[i+1])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      c_msb_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      c_msb_q <= c_msb_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    accept    = in_valid && in_ready;
    last_beat = (cnt_q == CNT_W'(BEATS - 1));

    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    c_msb_d = c_msb_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          a_sh_d  = a;
          b_sh_d  = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sh_d  = a_sh_q >> CHUNK;
        b_sh_d  = b_sh_q >> CHUNK;
        // Result bits enter from the MSB side so that after BEATS shifts the
        // first chunk sits at bit 0.
        sum_d   = (sum_q >> CHUNK) | (WIDTH'(chunk_s) << (WIDTH - CHUNK));
        carry_d = chain_c[CHUNK];
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_beat) begin
          c_msb_d = chain_c[CHUNK-1];
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = rst_n && (state_q == IDLE);
    out_valid = (state_q == DONE);
    sum       = sum_q;
    cout      = carry_q;
    ovf       = c_msb_q ^ carry_q;
  end

endmodule
